mem_shim_arbiter: RTL and testbench

//  Parametrised byte-serial memory shim: NCH requesters (e.g. ch0 = ifetch,
//  ch1 = data) share one 8-bit RAM/IO bus. Per request, moves 1..MAX_BYTES

---
 rtl/mem_shim_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 38 +++
 rtl/mem_shim_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_mem_shim_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_shim_pkg.sv
// Shared types and helpers for the byte-serial memory shim: FSM state encoding,
// derived-width helpers and field offsets into the flattened per-channel buses.
package mem_shim_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a byte-count field able to hold 0..max_bytes.
  function automatic int len_w_of(input int max_bytes);
    return $clog2(max_bytes + 1);
  endfunction

  // Width of a channel index; a single channel still needs one bit.
  function automatic int ch_w_of(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  // LSB position of channel ch's field in a bus packing NCH fields of width w.
  function automatic int fld_lo(input int ch, input int w);
    return ch * w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant to the first requester at or
// after a registered pointer; the pointer loads ptr when advance is high.
module rr_arbiter
  import mem_shim_pkg::*;
#(
  parameter int NCH = 2,
  localparam int CH_W = ch_w_of(NCH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NCH-1:0]  req,
  input  logic [CH_W-1:0] ptr,
  input  logic            advance,
  output logic [NCH-1:0]  gnt
);

  logic [CH_W-1:0] ptr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= ptr;
    end
  end

  // Scan from the farthest offset down so the nearest requester wins.
  always_comb begin
    gnt = '0;
    for (int o = NCH - 1; o >= 0; o--) begin
      if (req[(int'(ptr_q) + o) % NCH]) begin
        gnt = '0;
        gnt[(int'(ptr_q) + o) % NCH] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_shim_arbiter.sv
// Byte-serial memory shim: NCH requesters share one 8-bit RAM/IO bus under
// round-robin arbitration. Optional counters enabled by `MEM_SHIM_STATS_EN.
module mem_shim_arbiter
  import mem_shim_pkg::*;
#(
  parameter int NCH       = 2,
  parameter int ADDR_W    = 32,
  parameter int MAX_BYTES = 6,
  parameter int RD_LAT    = 1,
  localparam int LEN_W    = len_w_of(MAX_BYTES)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NCH-1:0]             req,
  input  logic [NCH-1:0]             write,
  input  logic [NCH*LEN_W-1:0]       len,
  input  logic [NCH*ADDR_W-1:0]      addr,
  input  logic [NCH*MAX_BYTES*8-1:0] wdata,
  output logic [NCH*MAX_BYTES*8-1:0] rdata,
  output logic [NCH-1:0]             done,
  output logic [NCH-1:0]             grant,
  output logic                       ram_use,
  output logic                       ram_read,
  output logic                       ram_write,
  output logic [ADDR_W-1:0]          ram_addr,
  output logic [7:0]                 ram_wdata,
  input  logic [7:0]                 ram_rdata
`ifdef MEM_SHIM_STATS_EN
  ,
  output logic [31:0]                stat_busy,
  output logic [NCH*16-1:0]          stat_xfers
`endif
);

  localparam int CH_W  = ch_w_of(NCH);
  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t                 state_q, state_d;
  logic [CH_W-1:0]        owner_q;
  logic [LEN_W-1:0]       idx_q;
  logic [LAT_W-1:0]       lat_q;
  logic                   wr_q;
  logic [LEN_W-1:0]       len_q;
  logic [ADDR_W-1:0]      base_q;
  logic [MAX_BYTES*8-1:0] wd_q;

  logic [NCH-1:0]         gnt;
  logic [CH_W-1:0]        gnt_ch;
  logic [CH_W-1:0]        ptr_next;
  logic                   sel_write;
  logic [LEN_W-1:0]       sel_len;
  logic [LEN_W-1:0]       len_eff;
  logic [ADDR_W-1:0]      sel_addr;
  logic [MAX_BYTES*8-1:0] sel_wdata;
  logic                   lat_last;
  logic                   step;
  logic                   byte_last;

  assign ptr_next = CH_W'((int'(owner_q) + 1) % NCH);

  rr_arbiter #(
    .NCH (NCH)
  ) u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .ptr     (ptr_next),
    .advance (state_q == DONE),
    .gnt     (gnt)
  );

  always_comb begin
    gnt_ch = '0;
    for (int c = 0; c < NCH; c++) begin
      if (gnt[c]) gnt_ch = CH_W'(c);
    end
  end

  assign sel_write = write[gnt_ch];
  assign sel_len   = len[fld_lo(int'(gnt_ch), LEN_W) +: LEN_W];
  assign sel_addr  = addr[fld_lo(int'(gnt_ch), ADDR_W) +: ADDR_W];
  assign sel_wdata = wdata[fld_lo(int'(gnt_ch), MAX_BYTES*8) +: MAX_BYTES*8];

  // A zero length still moves one byte; oversize requests are clipped.
  assign len_eff = (sel_len == '0) ? LEN_W'(1) :
                   (sel_len > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : sel_len;

  // Writes advance every cycle; reads wait out the RAM latency per byte.
  assign lat_last  = (lat_q == LAT_W'(RD_LAT - 1));
  assign step      = wr_q | lat_last;
  assign byte_last = (idx_q == len_q - LEN_W'(1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req) state_d = XFER;
      XFER:    if (step && byte_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant     = '0;
    done      = '0;
    ram_use   = 1'b0;
    ram_read  = 1'b0;
    ram_write = 1'b0;
    ram_addr  = '0;
    ram_wdata = 8'h00;
    for (int c = 0; c < NCH; c++) begin
      grant[c] = (state_q == XFER) && (owner_q == CH_W'(c));
      done[c]  = (state_q == DONE) && (owner_q == CH_W'(c));
    end
    if (state_q == XFER) begin
      ram_use   = 1'b1;
      ram_read  = ~wr_q;
      ram_write = wr_q;
      ram_addr  = base_q + ADDR_W'(idx_q);
      ram_wdata = wr_q ? wd_q[int'(idx_q)*8 +: 8] : 8'h00;
    end
  end

  // ---- control registers and read-data capture ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      idx_q   <= '0;
      lat_q   <= '0;
      rdata   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (|req) begin
            owner_q <= gnt_ch;
            idx_q   <= '0;
            lat_q   <= '0;
            if (!sel_write) begin
              for (int k = 0; k < MAX_BYTES; k++) begin
                if (LEN_W'(k) >= len_eff)
                  rdata[(int'(gnt_ch)*MAX_BYTES + k)*8 +: 8] <= 8'h00;
              end
            end
          end
        end
        XFER: begin
          if (!wr_q && lat_last)
            rdata[(int'(owner_q)*MAX_BYTES + int'(idx_q))*8 +: 8] <= ram_rdata;
          if (step) begin
            idx_q <= idx_q + LEN_W'(1);
            lat_q <= '0;
          end else begin
            lat_q <= lat_q + LAT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // ---- transfer descriptor latched at grant ----
  always_ff @(posedge clk) begin
    if (state_q == IDLE && (|req)) begin
      wr_q   <= sel_write;
      len_q  <= len_eff;
      base_q <= sel_addr;
      wd_q   <= sel_wdata;
    end
  end

`ifdef MEM_SHIM_STATS_EN
  // Saturating activity counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_busy  <= '0;
      stat_xfers <= '0;
    end else begin
      if (state_q != IDLE && stat_busy != 32'hFFFF_FFFF)
        stat_busy <= stat_busy + 32'd1;
      for (int c = 0; c < NCH; c++) begin
        if (done[c] && stat_xfers[c*16 +: 16] != 16'hFFFF)
          stat_xfers[c*16 +: 16] <= stat_xfers[c*16 +: 16] + 16'd1;
      end
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_mem_shim_arbiter.sv
// Self-checking bench for mem_shim_arbiter: transaction-level reference model,
// per-cycle output comparison, directed scenarios and randomized traffic.
module tb_mem_shim_arbiter;

  localparam int NCH    = 2;
  localparam int ADDR_W = 32;
  localparam int MB     = 6;
  localparam int RD_LAT = 1;
  localparam int LEN_W  = $clog2(MB + 1);
  localparam int RW     = NCH * MB * 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   reset;
  logic [NCH-1:0]         req, write;
  logic [NCH*LEN_W-1:0]   len;
  logic [NCH*ADDR_W-1:0]  addr;
  logic [RW-1:0]          wdata, rdata;
  logic [NCH-1:0]         done, grant;
  logic                   ram_use, ram_read, ram_write;
  logic [ADDR_W-1:0]      ram_addr;
  logic [7:0]             ram_wdata, ram_rdata;

  function automatic logic [7:0] ram_fn(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24];
  endfunction

  assign ram_rdata = ram_fn(ram_addr);

  mem_shim_arbiter #(
    .NCH       (NCH),
    .ADDR_W    (ADDR_W),
    .MAX_BYTES (MB),
    .RD_LAT    (RD_LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .write     (write),
    .len       (len),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .done      (done),
    .grant     (grant),
    .ram_use   (ram_use),
    .ram_read  (ram_read),
    .ram_write (ram_write),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: one transfer in flight, timed by a cycle offset.
  bit          m_act = 1'b0;
  int          m_t, m_ch, m_len, m_ptr;
  bit          m_wr;
  logic [31:0] m_base;
  logic [7:0]  m_wd [MB];
  logic [7:0]  m_rd [NCH][MB];

  function automatic int eff_len(input int l);
    if (l == 0) return 1;
    if (l > MB) return MB;
    return l;
  endfunction

  function automatic int m_total();
    return m_wr ? m_len : m_len * RD_LAT;
  endfunction

  function automatic int m_byte();
    return m_wr ? m_t : m_t / RD_LAT;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_act = 1'b0;
      m_t   = 0;
      m_ptr = 0;
      foreach (m_rd[c, k]) m_rd[c][k] = 8'h00;
    end else if (!m_act) begin
      if (req != '0) begin
        m_ch = -1;
        for (int o = 0; o < NCH; o++)
          if (m_ch < 0 && req[(m_ptr + o) % NCH]) m_ch = (m_ptr + o) % NCH;
        m_wr   = write[m_ch];
        m_len  = eff_len(int'(len[m_ch*LEN_W +: LEN_W]));
        m_base = addr[m_ch*ADDR_W +: ADDR_W];
        for (int k = 0; k < MB; k++) m_wd[k] = wdata[(m_ch*MB + k)*8 +: 8];
        if (!m_wr)
          for (int k = m_len; k < MB; k++) m_rd[m_ch][k] = 8'h00;
        m_act = 1'b1;
        m_t   = 0;
      end
    end else if (m_t < m_total()) begin
      if (!m_wr && (m_t % RD_LAT) == RD_LAT - 1)
        m_rd[m_ch][m_byte()] = ram_fn(m_base + 32'(m_byte()));
      m_t++;
    end else begin
      m_act = 1'b0;
      m_ptr = (m_ch + 1) % NCH;
    end
  end

  always @(negedge clk) begin
    logic [NCH-1:0]    e_grant, e_done;
    logic              e_use, e_read, e_write;
    logic [ADDR_W-1:0] e_addr;
    logic [7:0]        e_wdata;
    logic [RW-1:0]     e_rdata;
    if (chk_en) begin
      e_grant = '0; e_done = '0; e_use = 1'b0; e_read = 1'b0; e_write = 1'b0;
      e_addr = '0; e_wdata = 8'h00; e_rdata = '0;
      if (m_act && m_t < m_total()) begin
        e_grant[m_ch] = 1'b1;
        e_use   = 1'b1;
        e_read  = !m_wr;
        e_write = m_wr;
        e_addr  = m_base + 32'(m_byte());
        e_wdata = m_wr ? m_wd[m_byte()] : 8'h00;
      end
      if (m_act && m_t == m_total()) e_done[m_ch] = 1'b1;
      for (int c = 0; c < NCH; c++)
        for (int k = 0; k < MB; k++) e_rdata[(c*MB + k)*8 +: 8] = m_rd[c][k];
      chk("grant",     128'(grant),     128'(e_grant));
      chk("done",      128'(done),      128'(e_done));
      chk("ram_use",   128'(ram_use),   128'(e_use));
      chk("ram_read",  128'(ram_read),  128'(e_read));
      chk("ram_write", 128'(ram_write), 128'(e_write));
      chk("ram_addr",  128'(ram_addr),  128'(e_addr));
      chk("ram_wdata", 128'(ram_wdata), 128'(e_wdata));
      chk("rdata",     128'(rdata),     128'(e_rdata));
    end
  end

  logic [31:0] log_addr [$];
  logic        log_wr   [$];
  logic [7:0]  log_data [$];

  always @(negedge clk) begin
    if (ram_use) begin
      log_addr.push_back(ram_addr);
      log_wr.push_back(ram_write);
      log_data.push_back(ram_wdata);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_wr.delete();
    log_data.delete();
  endtask

  task automatic xfer(input int ch, input bit wr, input int l, input logic [31:0] a,
                      input logic [47:0] wd, output int cyc);
    write[ch] = wr;
    len[ch*LEN_W +: LEN_W]   = LEN_W'(l);
    addr[ch*ADDR_W +: ADDR_W] = a;
    wdata[ch*MB*8 +: MB*8]   = wd;
    clear_log();
    req[ch] = 1'b1;
    cyc = 1;
    step();
    cyc++;
    req[ch] = 1'b0;
    while (done[ch] !== 1'b1 && cyc < 60) begin
      step();
      cyc++;
    end
    chk("xfer_done_seen", 128'(done[ch]), 128'(1));
    step();
  endtask

  initial begin
    int cyc;
    int order [$];
    bit saw_bus;
    reset = 1'b1; req = '0; write = '0; len = '0; addr = '0; wdata = '0;

    // Reset
    step();
    chk_en = 1'b1;
    step();
    chk("rst_grant", 128'(grant), 128'(0));
    chk("rst_done",  128'(done),  128'(0));
    chk("rst_use",   128'(ram_use), 128'(0));
    chk("rst_rw",    128'({ram_read, ram_write}), 128'(0));
    chk("rst_addr",  128'(ram_addr), 128'(0));
    chk("rst_rdata", 128'(rdata), 128'(0));
    reset = 1'b0;
    step();

    // Single 6-byte read
    xfer(0, 1'b0, 6, 32'h10, 48'h0, cyc);
    chk("rd6_latency", 128'(cyc), 128'(8));
    chk("rd6_rdata",   128'(rdata[47:0]), 128'(48'h151413121110));
    chk("rd6_nbytes",  128'(log_addr.size()), 128'(6));
    for (int i = 0; i < log_addr.size(); i++)
      chk("rd6_addr", 128'({log_wr[i], log_addr[i]}), 128'({1'b0, 32'h10 + 32'(i)}));

    // 4-byte write
    xfer(1, 1'b1, 4, 32'hF000, 48'hDEAD_BEEF, cyc);
    chk("wr4_latency", 128'(cyc), 128'(6));
    chk("wr4_nbytes",  128'(log_addr.size()), 128'(4));
    for (int i = 0; i < log_addr.size(); i++)
      chk("wr4_byte", 128'({log_wr[i], log_addr[i], log_data[i]}),
          128'({1'b1, 32'hF000 + 32'(i), 8'((48'hDEAD_BEEF >> (8*i)) & 48'hFF)}));

    // Contention, both held
    write = '0;
    len   = {LEN_W'(1), LEN_W'(1)};
    addr  = {32'h200, 32'h100};
    req   = 2'b11;
    for (int i = 0; i < 100 && order.size() < 4; i++) begin
      step();
      for (int c = 0; c < NCH; c++) if (done[c]) order.push_back(c);
    end
    req = '0;
    chk("rr_count", 128'(order.size()), 128'(4));
    for (int i = 0; i < order.size(); i++)
      chk("rr_order", 128'(order[i]), 128'(i % 2));
    repeat (4) step();

    // Length and address boundaries
    xfer(0, 1'b0, 0, 32'h20, 48'h0, cyc);
    chk("len0_nbytes", 128'(log_addr.size()), 128'(1));
    chk("len0_rdata",  128'(rdata[47:0]), 128'(48'h20));
    xfer(1, 1'b0, 7, 32'h30, 48'h0, cyc);
    chk("len7_nbytes", 128'(log_addr.size()), 128'(6));
    chk("len7_rdata",  128'(rdata[95:48]), 128'(48'h353433323130));
    xfer(0, 1'b1, 2, 32'hFFFF_FFFF, 48'hA55A, cyc);
    chk("wrap_nbytes", 128'(log_addr.size()), 128'(2));
    if (log_addr.size() == 2) begin
      chk("wrap_b0", 128'({log_addr[0], log_data[0]}), 128'({32'hFFFF_FFFF, 8'h5A}));
      chk("wrap_b1", 128'({log_addr[1], log_data[1]}), 128'({32'h0, 8'hA5}));
    end

    // Reset during byte 2 of a read
    write[0] = 1'b0;
    len[LEN_W-1:0] = LEN_W'(6);
    addr[ADDR_W-1:0] = 32'h40;
    req[0] = 1'b1;
    step();
    req[0] = 1'b0;
    step();
    step();
    chk("mid_addr", 128'(ram_addr), 128'(32'h42));
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_use",   128'(ram_use), 128'(0));
    chk("mid_rst_rdata", 128'(rdata), 128'(0));
    saw_bus = 1'b0;
    repeat (8) begin
      step();
      if (done != '0 || ram_use || ram_read || ram_write) saw_bus = 1'b1;
    end
    chk("mid_rst_quiet", 128'(saw_bus), 128'(0));

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(499) == 0);
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(3) == 0) begin
          write[c] = $urandom_range(1);
          len[c*LEN_W +: LEN_W] = LEN_W'($urandom_range(7));
          addr[c*ADDR_W +: ADDR_W] = ($urandom_range(7) == 0) ?
                                     32'hFFFF_FFFC + 32'($urandom_range(3)) : 32'($urandom);
          wdata[c*MB*8 +: MB*8] = {16'($urandom), 32'($urandom)};
        end
        if (!req[c] && $urandom_range(2) == 0) req[c] = 1'b1;
        else if (req[c] && $urandom_range(7) == 0) req[c] = 1'b0;
      end
      step();
    end
    reset = 1'b0;
    req = '0;
    repeat (20) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
